// File: rtl/fuzz_top_datapath.sv
// Registered mixed-arithmetic datapath packing all state into status word y.
// Optional macro ACC_SAT_EN: saturate the accumulator instead of wrapping.
module fuzz_top_datapath #(
    parameter int          HIST_DEPTH = 10,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [19:0]                  wire0,
    input  logic [12:0]                  wire1,
    input  logic [20:0]                  wire2,
    input  logic [17:0]                  wire3,
    output logic [260+28*HIST_DEPTH:0]   y
);

    logic [19:0] r0;
    logic [12:0] r1;
    logic [20:0] r2;
    logic [17:0] r3;

    logic [20:0] sum;
    logic [21:0] diff;
    logic [33:0] prod;
    logic [63:0] acc;
    logic [31:0] lfsr;
    logic [15:0] cnt;
    logic [27:0] hist [HIST_DEPTH];

    logic [33:0] r1_x;
    logic [33:0] r2_x;
    logic [33:0] p;
    logic [27:0] f;
    logic [63:0] acc_nxt;
    logic [28*HIST_DEPTH-1:0] hflat;

    assign r1_x = {{21{r1[12]}}, r1};
    assign r2_x = {{13{r2[20]}}, r2};
    // Both operands pre-extended to 34 bits, so the low 34 bits are exact.
    assign p    = r1_x * r2_x;
    assign f    = {r2[20:13], r0 ^ {2'b00, r3}};

`ifdef ACC_SAT_EN
    logic [64:0] acc_ext;
    assign acc_ext = {acc[63], acc} + {{31{p[33]}}, p};

    always_comb begin
        acc_nxt = acc_ext[63:0];
        if (acc_ext[64] != acc_ext[63]) begin
            acc_nxt = acc_ext[64] ? 64'h8000_0000_0000_0000
                                  : 64'h7FFF_FFFF_FFFF_FFFF;
        end
    end
`else
    assign acc_nxt = acc + {{30{p[33]}}, p};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0   <= '0;
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
            sum  <= '0;
            diff <= '0;
            prod <= '0;
            acc  <= '0;
            lfsr <= LFSR_SEED;
            cnt  <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            r0   <= wire0;
            r1   <= wire1;
            r2   <= wire2;
            r3   <= wire3;
            sum  <= {1'b0, r0} + {3'b000, r3};
            diff <= {r2[20], r2} - {{9{r1[12]}}, r1};
            prod <= p;
            acc  <= acc_nxt;
            lfsr <= {lfsr[30:0],
                     lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            cnt  <= cnt + 16'd1;
            hist[0] <= f;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    always_comb begin
        hflat = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hflat[28*i +: 28] = hist[i];
        end
    end

    assign y = {acc, prod, sum, diff, r0, r1, r2, r3,
                lfsr, cnt, hflat};

endmodule

// File: tb/tb_fuzz_top_datapath.sv
// Randomized self-checking bench for fuzz_top_datapath.
// Expected y comes from an arithmetic reference model of the datapath.
module tb_fuzz_top_datapath;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [19:0]  wire0 = '0;
    logic [12:0]  wire1 = '0;
    logic [20:0]  wire2 = '0;
    logic [17:0]  wire3 = '0;
    logic [540:0] y;

    int passed = 0;
    int total  = 0;

    fuzz_top_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .y     (y)
    );

    always #5 clk = ~clk;

    // Reference model: operands held as plain integers.
    longint      ma, mb, mc, md;
    longint      msum, mdiff, mprod;
    logic [63:0] macc;
    logic [31:0] mlfsr;
    logic [15:0] mcnt;
    logic [27:0] mh [10];

    task automatic model_reset();
        ma = 0; mb = 0; mc = 0; md = 0;
        msum = 0; mdiff = 0; mprod = 0;
        macc = '0;
        mlfsr = 32'h0000_0001;
        mcnt = '0;
        for (int i = 0; i < 10; i++) mh[i] = '0;
    endtask

    function automatic logic [540:0] exp_y();
        logic [279:0] h;
        h = '0;
        for (int i = 0; i < 10; i++) h[28*i +: 28] = mh[i];
        return {macc, 34'(mprod), 21'(msum), 22'(mdiff),
                20'(ma), 13'(mb), 21'(mc), 18'(md),
                mlfsr, mcnt, h};
    endfunction

    function automatic logic [540:0] reset_y();
        logic [540:0] v;
        v = '0;
        v[327:296] = 32'h0000_0001;
        return v;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge.
    task automatic tick();
        longint a, b, c, d, np;
        logic [27:0] f;
`ifdef ACC_SAT_EN
        logic signed [64:0] s;
`endif
        @(posedge clk);
        a = longint'(wire0);
        b = longint'($signed(wire1));
        c = longint'($signed(wire2));
        d = longint'(wire3);
        np = mb * mc;
        f = {8'(mc >>> 13), 20'(ma ^ md)};
        for (int i = 9; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = f;
`ifdef ACC_SAT_EN
        s = $signed({macc[63], macc}) + 65'(np);
        if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF)
            macc = 64'h7FFF_FFFF_FFFF_FFFF;
        else if (s < -65'sh0_8000_0000_0000_0000)
            macc = 64'h8000_0000_0000_0000;
        else
            macc = s[63:0];
`else
        macc = macc + 64'(np);
`endif
        msum  = ma + md;
        mdiff = mc - mb;
        mprod = np;
        mlfsr = {mlfsr[30:0],
                 mlfsr[31] ^ mlfsr[21] ^ mlfsr[1] ^ mlfsr[0]};
        mcnt  = mcnt + 16'd1;
        ma = a; mb = b; mc = c; md = d;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (y !== reset_y())
            $display("FAIL reset_state y=%h want=%h", y, reset_y());
        else passed++;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (y !== reset_y())
            $display("FAIL reset_held y=%h want=%h", y, reset_y());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        wire0 = 20'd5; wire1 = 13'd3; wire2 = 21'd4; wire3 = 18'd2;
        tick();
        total++;
        if ({y[399:380], y[379:367], y[366:346], y[345:328]} !==
            {20'd5, 13'd3, 21'd4, 18'd2})
            $display("FAIL basic_r r0=%0d r1=%0d r2=%0d r3=%0d",
                     y[399:380], y[379:367], y[366:346], y[345:328]);
        else passed++;
        total++;
        if (y[327:296] !== 32'h3 || y[295:280] !== 16'd1)
            $display("FAIL lfsr_cnt1 lfsr=%h cnt=%h want 3/1",
                     y[327:296], y[295:280]);
        else passed++;
        tick();
        total++;
        if (y[442:422] !== 21'd7 || y[421:400] !== 22'd1 ||
            y[476:443] !== 34'd12 || y[540:477] !== 64'd12 ||
            y[27:0] !== 28'h7)
            $display("FAIL basic_e2 sum=%0d diff=%0d prod=%0d acc=%0d h0=%h",
                     y[442:422], y[421:400], y[476:443],
                     y[540:477], y[27:0]);
        else passed++;
        total++;
        if (y[327:296] !== 32'h6 || y[295:280] !== 16'd2)
            $display("FAIL lfsr_cnt2 lfsr=%h cnt=%h want 6/2",
                     y[327:296], y[295:280]);
        else passed++;
        tick();
        total++;
        if (y[540:477] !== 64'd24)
            $display("FAIL basic_acc acc=%0d want=24", y[540:477]);
        else passed++;
        total++;
        if (y[327:296] !== 32'hD || y[295:280] !== 16'd3)
            $display("FAIL lfsr_cnt3 lfsr=%h cnt=%h want D/3",
                     y[327:296], y[295:280]);
        else passed++;
        total++;
        if (y !== exp_y())
            $display("FAIL basic_model y=%h want=%h", y, exp_y());
        else passed++;
    endtask

    task automatic test_history();
        int bad;
        repeat (8) tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (y[28*i +: 28] !== 28'h7) begin
                $display("FAIL hist_fill slot=%0d got=%h want=7",
                         i, y[28*i +: 28]);
                bad++;
            end else passed++;
        end
        wire0 = '0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            total++;
            if (y !== exp_y())
                $display("FAIL hist_shift edge=%0d y=%h want=%h",
                         k, y, exp_y());
            else passed++;
            if (k == 2) begin
                total++;
                if (y[27:0] !== 28'h2 || y[55:28] !== 28'h7)
                    $display("FAIL hist_h0 h0=%h h1=%h want 2/7",
                             y[27:0], y[55:28]);
                else passed++;
            end
        end
    endtask

    task automatic test_signed();
        logic [63:0] a0;
        wire0 = '0; wire3 = '0;
        wire1 = 13'h1FFF; wire2 = 21'h000002;
        repeat (2) tick();
        total++;
        if (y[476:443] !== 34'h3_FFFF_FFFE || y[421:400] !== 22'd3)
            $display("FAIL signed prod=%h diff=%0d want 3FFFFFFFE/3",
                     y[476:443], y[421:400]);
        else passed++;
        a0 = y[540:477];
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (y[540:477] !== a0 - 64'(2 * k))
                $display("FAIL signed_acc edge=%0d acc=%h want=%h",
                         k, y[540:477], a0 - 64'(2 * k));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            wire0 = 20'($urandom);
            wire1 = 13'($urandom);
            wire2 = 21'($urandom);
            wire3 = 18'($urandom);
            tick();
            total++;
            if (y !== exp_y())
                $display("FAIL random it=%0d y=%h want=%h", k, y, exp_y());
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (y !== reset_y())
            $display("FAIL async_reset y=%h want=%h", y, reset_y());
        else passed++;
        model_reset();
        #2 rst_n = 1'b1;
        tick();
        total++;
        if (y[327:296] !== 32'h3 || y[295:280] !== 16'd1)
            $display("FAIL post_reset lfsr=%h cnt=%h want 3/1",
                     y[327:296], y[295:280]);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (y !== exp_y())
                $display("FAIL post_reset_seq it=%0d y=%h want=%h",
                         k, y, exp_y());
            else passed++;
        end
    endtask

    task automatic test_cnt_wrap();
        int n;
        n = 0;
        while (mcnt != 16'd0 && n < 70000) begin
            wire0 = 20'($urandom);
            wire1 = 13'($urandom);
            wire2 = 21'($urandom);
            wire3 = 18'($urandom);
            tick();
            n++;
        end
        total++;
        if (y[295:280] !== 16'd0 || mcnt != 16'd0)
            $display("FAIL cnt_wrap cnt=%h want=0 edges=%0d",
                     y[295:280], n);
        else passed++;
        total++;
        if (y !== exp_y())
            $display("FAIL cnt_wrap_model y=%h want=%h", y, exp_y());
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_history();
        test_signed();
        test_random();
        test_async_reset();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
